frame_seq_ctrl: RTL and testbench

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

---
 rtl/frame_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_seq_ctrl.sv
// Frame sequencing controller: receive a full image, run it through the edge
// detector, wait for the UART to drain, and report completion or errors.
module frame_seq_ctrl #(
    parameter int IMG_WIDTH      = 80,
    parameter int IMG_HEIGHT     = 120,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        rx_pixel_done,
    input  logic        rx_frame_done,
    input  logic        canny_de,
    input  logic        tx_busy,
    output logic        rx_enable,
    output logic        rx_clear,
    output logic        start_read,
    output logic        busy,
    output logic        frame_ok,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [2:0]  state
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [WW-1:0] TMO_C   = WW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_PROC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_TIMEOUT = 2'd1;
    localparam logic [1:0] E_SIZE    = 2'd2;
    localparam logic [1:0] E_OVERRUN = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, rx_cnt_inc;
    logic [CW-1:0] out_cnt_q, out_cnt_d, out_cnt_inc;
    logic [WW-1:0] wd_q, wd_d, wd_inc;
    logic          wd_tmo, wd_act, wd_run;
    logic          armed_q, armed_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [15:0]   frame_cnt_q;
    logic          start_read_q, frame_ok_q, err_pulse_q, rx_clear_q;

    always_comb begin
        rx_cnt_inc = rx_cnt_q;
        if (rx_pixel_done && (rx_cnt_q != TOTAL_C))
            rx_cnt_inc = rx_cnt_q + CW'(1);
        out_cnt_inc = out_cnt_q + CW'(1);
        wd_inc      = wd_q + WW'(1);
        wd_tmo      = (wd_inc == TMO_C);
    end

    // Completion and overrun checks precede the timeout test in every state.
    always_comb begin
        state_d    = state_q;
        rx_cnt_d   = rx_cnt_q;
        out_cnt_d  = out_cnt_q;
        armed_d    = armed_q;
        err_code_d = err_code_q;
        wd_act     = 1'b0;
        wd_run     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_RX;
                    rx_cnt_d   = '0;
                    out_cnt_d  = '0;
                    armed_d    = 1'b0;
                    err_code_d = E_NONE;
                end
            end
            S_RX: begin
                wd_act   = rx_pixel_done;
                wd_run   = armed_q;
                rx_cnt_d = rx_cnt_inc;
                if (rx_pixel_done)
                    armed_d = 1'b1;
                if (rx_frame_done) begin
                    if (rx_cnt_inc == TOTAL_C) begin
                        state_d = S_PROC;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = E_SIZE;
                    end
                end else if (armed_q && !rx_pixel_done && wd_tmo) begin
                    state_d    = S_ERR;
                    err_code_d = E_TIMEOUT;
                end
            end
            S_PROC: begin
                wd_act = canny_de;
                wd_run = 1'b1;
                if (rx_frame_done) begin
                    state_d    = S_ERR;
                    err_code_d = E_OVERRUN;
                end else if (canny_de) begin
                    out_cnt_d = out_cnt_inc;
                    if (out_cnt_inc == TOTAL_C)
                        state_d = S_DRAIN;
                end else if (wd_tmo) begin
                    state_d    = S_ERR;
                    err_code_d = E_TIMEOUT;
                end
            end
            S_DRAIN: begin
                wd_run = 1'b1;
                if (rx_frame_done) begin
                    state_d    = S_ERR;
                    err_code_d = E_OVERRUN;
                end else if (!tx_busy) begin
                    state_d = S_DONE;
                end else if (wd_tmo) begin
                    state_d    = S_ERR;
                    err_code_d = E_TIMEOUT;
                end
            end
            S_DONE: begin
                if (rx_frame_done) begin
                    state_d    = S_ERR;
                    err_code_d = E_OVERRUN;
                end else if (enable) begin
                    state_d    = S_RX;
                    rx_cnt_d   = '0;
                    out_cnt_d  = '0;
                    armed_d    = 1'b0;
                    err_code_d = E_NONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || wd_act)
            wd_d = '0;
        else if (wd_run)
            wd_d = wd_inc;
        else
            wd_d = wd_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rx_cnt_q     <= '0;
            out_cnt_q    <= '0;
            wd_q         <= '0;
            armed_q      <= 1'b0;
            err_code_q   <= E_NONE;
            frame_cnt_q  <= '0;
            start_read_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
            rx_clear_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_cnt_q     <= rx_cnt_d;
            out_cnt_q    <= out_cnt_d;
            wd_q         <= wd_d;
            armed_q      <= armed_d;
            err_code_q   <= err_code_d;
            start_read_q <= (state_q == S_RX) && (state_d == S_PROC);
            frame_ok_q   <= (state_d == S_DONE);
            err_pulse_q  <= (state_d == S_ERR);
            rx_clear_q   <= (state_d == S_ERR);
            if (state_d == S_DONE)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign state       = state_q;
    assign rx_enable   = (state_q == S_RX);
    assign busy        = (state_q != S_IDLE);
    assign rx_clear    = rx_clear_q;
    assign start_read  = start_read_q;
    assign frame_ok    = frame_ok_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl (4x2 image, 16-cycle watchdog) with an
// event scoreboard for frame_ok / err_pulse.
module tb_frame_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        rx_pixel_done = 1'b0;
    logic        rx_frame_done = 1'b0;
    logic        canny_de = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_enable, rx_clear, start_read, busy, frame_ok, err_pulse;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [2:0]  state;

    frame_seq_ctrl #(
        .IMG_WIDTH      (4),
        .IMG_HEIGHT     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .rx_pixel_done (rx_pixel_done),
        .rx_frame_done (rx_frame_done),
        .canny_de      (canny_de),
        .tx_busy       (tx_busy),
        .rx_enable     (rx_enable),
        .rx_clear      (rx_clear),
        .start_read    (start_read),
        .busy          (busy),
        .frame_ok      (frame_ok),
        .err_pulse     (err_pulse),
        .err_code      (err_code),
        .frame_count   (frame_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [15:0] cnt;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  sr_seen  = 0;
    int  n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ok(input logic [15:0] cnt);
        sb.push_back('{is_err: 1'b0, code: 2'd0, cnt: cnt});
    endtask

    task automatic push_err(input logic [1:0] code);
        sb.push_back('{is_err: 1'b1, code: code, cnt: 16'd0});
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        if (start_read) sr_seen++;
        if (frame_ok || err_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {frame_ok, err_pulse}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {frame_ok, err_pulse}, e.is_err ? 2'b01 : 2'b10);
                if (e.is_err) begin
                    chk("err_code", err_code, e.code);
                    chk("rx_clear", rx_clear, 1'b1);
                end else begin
                    chk("frame_count", frame_count, e.cnt);
                end
            end
        end
    endtask

    task automatic send_pixels(input int cnt, input bit done_with_last);
        for (int i = 0; i < cnt; i++) begin
            rx_pixel_done = 1'b1;
            if (done_with_last && i == cnt - 1) rx_frame_done = 1'b1;
            tick();
        end
        rx_pixel_done = 1'b0;
        if (!done_with_last) begin
            rx_frame_done = 1'b1;
            tick();
        end
        rx_frame_done = 1'b0;
    endtask

    task automatic send_canny(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            canny_de = 1'b1;
            tick();
        end
        canny_de = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_count", frame_count, 16'd0);
        chk("rst_err_code", err_code, 2'd0);
        chk("rst_pulses", {rx_enable, rx_clear, start_read, frame_ok, err_pulse}, 5'd0);
        rstn = 1'b1;

        // Nominal frame, enable held high
        enable = 1'b1;
        tick();
        chk("f1_state_rx", state, 3'd1);
        chk("f1_rx_enable", rx_enable, 1'b1);
        send_pixels(8, 1'b0);
        chk("f1_state_proc", state, 3'd2);
        chk("f1_start_read", start_read, 1'b1);
        push_ok(16'd1);
        send_canny(1);
        chk("f1_start_read_once", start_read, 1'b0);
        send_canny(7);
        chk("f1_state_drain", state, 3'd3);
        tick();
        chk("f1_state_done", state, 3'd4);
        tick();
        chk("f1_back_to_rx", state, 3'd1);

        // Second frame: done with last pixel, TX busy, enable dropped mid-frame
        enable = 1'b0;
        send_pixels(8, 1'b1);
        chk("f2_state_proc", state, 3'd2);
        tx_busy = 1'b1;
        push_ok(16'd2);
        send_canny(8);
        repeat (3) tick();
        chk("f2_drain_hold", state, 3'd3);
        tx_busy = 1'b0;
        tick();
        tick();
        chk("f2_idle_after", state, 3'd0);
        chk("f2_busy_low", busy, 1'b0);

        // Short frame
        enable = 1'b1;
        tick();
        enable = 1'b0;
        push_err(2'd2);
        send_pixels(7, 1'b0);
        chk("short_state_err", state, 3'd5);
        tick();
        chk("short_state_idle", state, 3'd0);
        chk("short_code_hold", err_code, 2'd2);
        chk("short_no_start_read", sr_seen, 2);

        // Stall: idle line before first pixel, then silence after third
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("stall_code_cleared", err_code, 2'd0);
        repeat (100) tick();
        chk("stall_unarmed", state, 3'd1);
        for (int i = 0; i < 3; i++) begin
            rx_pixel_done = 1'b1;
            tick();
        end
        rx_pixel_done = 1'b0;
        push_err(2'd1);
        n = 0;
        while (!err_pulse && n < 40) begin
            tick();
            n++;
        end
        chk("stall_latency", n, 16);
        chk("stall_state_err", state, 3'd5);
        tick();

        // Tie: final canny_de on the cycle the watchdog would expire
        enable = 1'b1;
        tick();
        enable = 1'b0;
        send_pixels(8, 1'b0);
        send_canny(7);
        repeat (15) tick();
        chk("tie_still_proc", state, 3'd2);
        push_ok(16'd3);
        send_canny(1);
        chk("tie_state_drain", state, 3'd3);
        tick();
        tick();
        chk("tie_idle", state, 3'd0);

        // Overrun during PROC
        enable = 1'b1;
        tick();
        enable = 1'b0;
        send_pixels(8, 1'b0);
        chk("ovr_state_proc", state, 3'd2);
        push_err(2'd3);
        rx_frame_done = 1'b1;
        tick();
        rx_frame_done = 1'b0;
        chk("ovr_state_err", state, 3'd5);
        tick();

        // Reset while draining
        enable = 1'b1;
        tick();
        enable = 1'b0;
        send_pixels(8, 1'b0);
        tx_busy = 1'b1;
        send_canny(8);
        chk("rstd_state_drain", state, 3'd3);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rstd_state", state, 3'd0);
        chk("rstd_frame_count", frame_count, 16'd0);
        chk("rstd_outputs", {busy, rx_enable, rx_clear, start_read, frame_ok, err_pulse}, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tx_busy = 1'b0;
        repeat (5) tick();
        chk("rstd_idle", state, 3'd0);

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        chk("wrap_preload", frame_count, 16'hFFFF);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        send_pixels(8, 1'b0);
        push_ok(16'h0000);
        send_canny(8);
        tick();
        chk("wrap_count", frame_count, 16'h0000);
        tick();
        chk("wrap_idle", state, 3'd0);

        chk("sb_empty", sb.size(), 0);
        chk("start_read_total", sr_seen, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
